// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate exerciser.
//   - gate_state_e : exerciser FSM encoding (IDLE=0, APPLY=1, FINISH=2)
//   - TT_*         : expected truth tables, bit i = Q for vector {A,B}=i
//   - NUM_VECTORS  : number of input vectors walked per run
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        FINISH = 2'd2
    } gate_state_e;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/gate_settle_counter.sv
// Settle-time down counter for the gate exerciser.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; holds at zero
//   zero       : count is zero
module gate_settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_exerciser.sv
// Stimulus/checker engine for a 2-input combinational gate. Walks {A,B}
// through 00,01,10,11, holds each vector SETTLE_CYCLES cycles, samples Q on
// the last edge of each hold window and compares it with EXPECT_TT.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : run request (level), only looked at while IDLE
//   A, B        : gate inputs, {A,B} = vector index
//   Q           : gate output under test
//   busy        : run in progress (APPLY)
//   done        : one-cycle completion pulse (FINISH)
//   pass        : last completed run had no mismatches
//   err_count   : mismatching vectors in the last run (0..4)
//   fail_vec    : bit i set when vector i mismatched
//   state_dbg   : current FSM state
//
// Handshake: start is a plain level request with no ready/ack. It is accepted
// on any edge where the FSM is IDLE and start=1; busy rises the following
// cycle. While busy or done is high, start is ignored, so a held start yields
// back-to-back runs separated by exactly one IDLE cycle.
module gate_exerciser
    import gate_test_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [3:0] EXPECT_TT     = 4'b0111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        A,
    output logic        B,
    input  logic        Q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_count,
    output logic [3:0]  fail_vec,
    output gate_state_e state_dbg
);

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    gate_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  fail_q, fail_d;
    logic [2:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    gate_settle_counter #(.W(4)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        err_d    = err_q;
        pass_d   = pass_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = APPLY;
                    idx_d    = 2'd0;
                    fail_d   = 4'b0000;
                    err_d    = 3'd0;
                    pass_d   = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            APPLY: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    // Last edge of this vector's hold window: sample Q.
                    if (Q != EXPECT_TT[idx_q]) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = FINISH;
                        // Registered with FINISH entry so it is valid alongside done.
                        pass_d  = (fail_d == 4'b0000);
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        cnt_load = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            fail_q  <= 4'b0000;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == APPLY);
    assign done      = (state_q == FINISH);
    assign A         = busy & idx_q[1];
    assign B         = busy & idx_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gate_exerciser.sv
module tb_gate_exerciser;
    import gate_test_pkg::*;

    // ---------------- clock / reset / DUTs ----------------
    logic clk;
    logic rst_n;
    logic start;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Truth table implemented by the gate model feeding each DUT's Q.
    logic [3:0] gate_tt [2];
    int         sv      [2];
    logic [3:0] etv     [2];

    logic a0, b0, q0, busy0, done0, pass0;
    logic a1, b1, q1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;
    gate_state_e st0, st1;

    assign q0 = gate_tt[0][{a0, b0}];
    assign q1 = gate_tt[1][{a1, b1}];

    gate_exerciser u_nand (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a0), .B(b0), .Q(q0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fail0), .state_dbg(st0)
    );

    gate_exerciser #(.SETTLE_CYCLES(3), .EXPECT_TT(TT_AND)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a1), .B(b1), .Q(q1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fail1), .state_dbg(st1)
    );

    logic [1:0] o_ab   [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic       o_pass [2];
    logic [2:0] o_err  [2];
    logic [3:0] o_fail [2];
    assign o_ab[0] = {a0, b0};   assign o_ab[1] = {a1, b1};
    assign o_busy[0] = busy0;    assign o_busy[1] = busy1;
    assign o_done[0] = done0;    assign o_done[1] = done1;
    assign o_pass[0] = pass0;    assign o_pass[1] = pass1;
    assign o_err[0]  = err0;     assign o_err[1]  = err1;
    assign o_fail[0] = fail0;    assign o_fail[1] = fail1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // A run accepted at edge k occupies cycles k+1..k+4S (vector (t-1)/S at
    // offset t), then cycle k+4S+1 carries done. Vector i is judged at edge
    // k+(i+1)S using the gate's truth table against the expected one.
    bit         m_active [2];
    int         m_k      [2];
    logic [3:0] m_fail   [2];
    logic [2:0] m_err    [2];
    logic       m_pass   [2];
    int         done_cyc [2];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic model_edge(input int e);
        for (int d = 0; d < 2; d++) begin
            int t;
            int i;
            logic [3:0] gt;
            logic [3:0] et;
            gt = gate_tt[d];
            et = etv[d];
            if (!rst_n) begin
                m_active[d] = 0;
                m_fail[d]   = 4'b0000;
                m_err[d]    = 3'd0;
                m_pass[d]   = 1'b0;
            end else if (m_active[d]) begin
                t = e - m_k[d];
                if (t == 4 * sv[d] + 1) begin
                    m_active[d] = 0;
                end else if (t % sv[d] == 0) begin
                    i = t / sv[d] - 1;
                    if (gt[i] != et[i]) begin
                        m_fail[d][i] = 1'b1;
                        m_err[d]     = m_err[d] + 3'd1;
                    end
                    if (t == 4 * sv[d]) begin
                        m_pass[d] = (m_fail[d] == 4'b0000);
                        if (d == 0) exp_q0.push_back({m_pass[d], m_err[d], m_fail[d]});
                        else        exp_q1.push_back({m_pass[d], m_err[d], m_fail[d]});
                    end
                end
            end else if (start) begin
                m_active[d] = 1;
                m_k[d]      = e;
                m_fail[d]   = 4'b0000;
                m_err[d]    = 3'd0;
                m_pass[d]   = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input int e);
        for (int d = 0; d < 2; d++) begin
            int tp;
            logic [1:0] ev;
            logic eb;
            logic ed;
            logic [7:0] res;
            ev = 2'd0; eb = 1'b0; ed = 1'b0;
            if (m_active[d]) begin
                tp = e + 1 - m_k[d];
                if (tp <= 4 * sv[d]) begin
                    eb = 1'b1;
                    ev = 2'((tp - 1) / sv[d]);
                end else begin
                    ed = 1'b1;
                end
            end
            check($sformatf("d%0d_ab", d),   o_ab[d],   ev);
            check($sformatf("d%0d_busy", d), o_busy[d], eb);
            check($sformatf("d%0d_done", d), o_done[d], ed);
            check($sformatf("d%0d_pass", d), o_pass[d], m_pass[d]);
            check($sformatf("d%0d_err", d),  o_err[d],  m_err[d]);
            check($sformatf("d%0d_fail", d), o_fail[d], m_fail[d]);
            if (o_done[d] === 1'b1) begin
                done_cyc[d] = e + 1;
                if (d == 0 && exp_q0.size() > 0) begin
                    res = exp_q0.pop_front();
                    check("d0_sb_result", {o_pass[0], o_err[0], o_fail[0]}, res);
                end else if (d == 1 && exp_q1.size() > 0) begin
                    res = exp_q1.pop_front();
                    check("d1_sb_result", {o_pass[1], o_err[1], o_fail[1]}, res);
                end else begin
                    check($sformatf("d%0d_unexpected_done", d), 1, 0);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic st, input logic rn);
        start = st;
        rst_n = rn;
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        @(negedge clk);
        compare_all(cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active[0] || m_active[1]) && n < 200) begin
            step(1'b0, 1'b1);
            n++;
        end
        if (m_active[0] || m_active[1]) check("wait_idle_timeout", 1, 0);
        step(1'b0, 1'b1);
    endtask

    task automatic run_once();
        step(1'b1, 1'b1);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sv[0] = 1;  etv[0] = TT_NAND;
        sv[1] = 3;  etv[1] = TT_AND;
        gate_tt[0] = TT_NAND;
        gate_tt[1] = TT_AND;
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_k[d] = 0; m_fail[d] = '0;
            m_err[d] = '0; m_pass[d] = 1'b0; done_cyc[d] = 0;
        end
        start = 1'b0;
        rst_n = 1'b0;

        // Reset
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_state0", st0, IDLE);
        check("rst_state1", st1, IDLE);
        check("rst_outs0", {a0, b0, busy0, done0, pass0, err0, fail0}, 12'h000);

        // Correct gates: NAND with S=1, AND with S=3
        run_once();
        check("nand_done_lat", done_cyc[0] - m_k[0], 5);
        check("and_done_lat",  done_cyc[1] - m_k[1], 13);
        check("nand_ok_res", {pass0, err0, fail0}, {1'b1, 3'd0, 4'b0000});
        check("and_ok_res",  {pass1, err1, fail1}, {1'b1, 3'd0, 4'b0000});

        // Stuck-at-1 and stuck-at-0 outputs on the NAND checker
        gate_tt[0] = 4'b1111;
        run_once();
        check("stuck1_res", {pass0, err0, fail0}, {1'b0, 3'd1, 4'b1000});
        gate_tt[0] = 4'b0000;
        run_once();
        check("stuck0_res", {pass0, err0, fail0}, {1'b0, 3'd3, 4'b0111});
        check("results_hold", {pass0, err0, fail0}, {1'b0, 3'd3, 4'b0111});

        // Reset during vector 2, then a normal run
        gate_tt[0] = TT_NAND;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("abort_vec2", {a0, b0}, 2'b10);
        step(1'b0, 1'b0);
        check("abort_cleared", {busy0, done0, pass0, err0, fail0}, 10'h000);
        step(1'b0, 1'b1);
        check("abort_no_done", done0, 1'b0);
        run_once();
        check("after_abort_res", {pass0, err0, fail0}, {1'b1, 3'd0, 4'b0000});

        // start pulsed mid-run is ignored
        gate_tt[1] = TT_OR;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        wait_idle();
        check("and_vs_or_res", {pass1, err1, fail1}, {1'b0, 3'd2, 4'b0110});

        // start held high: back-to-back runs with one IDLE cycle between
        gate_tt[1] = TT_AND;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        wait_idle();

        // Randomized traffic, random gate functions, occasional reset
        for (int i = 0; i < 600; i++) begin
            if (!m_active[0] && !m_active[1] && $urandom_range(0, 3) == 0) begin
                gate_tt[0] = ($urandom_range(0, 1) == 0) ? TT_NAND : 4'($urandom_range(0, 15));
                gate_tt[1] = ($urandom_range(0, 1) == 0) ? TT_AND  : 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) != 0));
        end
        wait_idle();
        check("sb_empty0", exp_q0.size(), 0);
        check("sb_empty1", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Stimulus and checker engine for a 2-input combinational gate. It drives the gate inputs A and B and reads back the gate output Q.
- Walks all four input vectors, samples Q after a programmable settle time, and compares each sample against an expected truth table.
- Reports a per-vector fail map, an error count and a pass flag.
- Sits on the test/bring-up side of the gate library: the driver and reader end of the gate's A/B→Q interface.

Parameters:
- SETTLE_CYCLES, 1, number of cycles each vector is held before Q is sampled; legal range 1..15.
- EXPECT_TT, 4'b0111, expected Q for vector index {A,B}: bit i = expected Q when {A,B}=i. The default is NAND.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a test run; sampled only in IDLE.
- A  output  1  gate input A (MSB of vector index).
- B  output  1  gate input B (LSB of vector index).
- Q  input  1  gate output under test.
- busy  output  1  high while a run is in progress.
- done  output  1  single-cycle pulse when a run completes.
- pass  output  1  high when the last completed run had zero mismatches.
- err_count  output  3  number of mismatching vectors in the last run, 0..4.
- fail_vec  output  4  bit i set if vector i mismatched in the last run.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, A=B=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, settle counter=0, vector index=0. Reset overrides everything, including a run in progress, and produces no done pulse.
- States: IDLE, APPLY, FINISH.
- IDLE:
  - A=B=0, busy=0.
  - If start=1 at edge k: go to APPLY, index=0, settle counter=SETTLE_CYCLES-1, and clear fail_vec, err_count and pass.
  - busy=1 and {A,B}=00 from the cycle after edge k.
- APPLY:
  - {A,B} = index; busy=1.
  - Each edge with counter≠0: decrement the counter.
  - Edge with counter=0:
    - Sample Q.
    - If Q ≠ EXPECT_TT[index], set fail_vec[index] and increment err_count.
    - If index<3: increment index, reload counter=SETTLE_CYCLES-1, stay in APPLY.
    - If index=3: go to FINISH.
- Timing for a run starting at edge k:
  - Vector i is driven during cycles k+1+i·S through k+(i+1)·S, where S=SETTLE_CYCLES.
  - Vector i is sampled at edge k+(i+1)·S.
  - With S=1: 00, 01, 10, 11 are driven in cycles k+1..k+4.
- FINISH (one cycle):
  - busy=0, done=1, A=B=0.
  - pass=1 if and only if fail_vec==0; pass is registered together with entry to FINISH, so it is valid while done=1.
  - Next state is always IDLE.
  - done is high during cycle k+4S+1 only.
- Results (pass, err_count, fail_vec) hold their values until the next accepted start or reset.
- start:
  - Ignored in APPLY and FINISH.
  - If start is held high continuously, the next run begins from IDLE, giving one IDLE cycle between runs.
- err_count saturates naturally at 4 because there are only four vectors; no wrap-around.
- Q is treated as combinational from A/B. The checker makes no assumption beyond the settle time. Q is sampled only at the last edge of each vector's hold window.

Decomposition:
- Shared package gate_test_pkg holds:
  - the state encoding localparams (IDLE=2'd0, APPLY=2'd1, FINISH=2'd2);
  - the truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110;
  - the vector count 4.
- No sub-module is required. If separated out, the settle counter becomes gate_settle_counter (load, decrement, zero flag).

Test Plan:
- Correct NAND wired to A/B/Q, SETTLE_CYCLES=1, start pulse at edge k → vectors 00, 01, 10, 11 in cycles k+1..k+4; done in cycle k+5; pass=1, err_count=0, fail_vec=4'b0000.
- Q tied to 1 (stuck-at-1), default EXPECT_TT → fail_vec=4'b1000, err_count=1, pass=0.
- Q tied to 0 → fail_vec=4'b0111, err_count=3, pass=0.
- SETTLE_CYCLES=3, EXPECT_TT=TT_AND, AND gate as DUT → each vector held 3 cycles; done in cycle k+13; pass=1.
- rst_n low for 1 cycle during vector 2 of a run, then start again → no done from the aborted run; all outputs return to 0; the new run completes normally.
- start pulsed again during APPLY, and start held high across two runs → the mid-run pulse has no effect; held start gives back-to-back runs with exactly one IDLE cycle between FINISH and the next vector 00; results are cleared at each accepted start.
